// File: rtl/vscale_htif_pcr_responder.sv
// Host-side PCR responder: serves tohost/fromhost CSR requests from the host
// one at a time, while the core updates the same registers in any state.
module vscale_htif_pcr_responder #(
    parameter int unsigned HTIF_PCR_WIDTH = 64,
    parameter logic [11:0] ADDR_TO_HOST   = 12'h780,
    parameter logic [11:0] ADDR_FROM_HOST = 12'h781
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      htif_pcr_req_valid,
    output logic                      htif_pcr_req_ready,
    input  logic                      htif_pcr_req_rw,
    input  logic [11:0]               htif_pcr_req_addr,
    input  logic [HTIF_PCR_WIDTH-1:0] htif_pcr_req_data,
    output logic                      htif_pcr_resp_valid,
    input  logic                      htif_pcr_resp_ready,
    output logic [HTIF_PCR_WIDTH-1:0] htif_pcr_resp_data,
    input  logic                      core_tohost_wen,
    input  logic [31:0]               core_tohost_wdata,
    output logic [31:0]               core_tohost,
    output logic [31:0]               core_fromhost,
    input  logic                      core_fromhost_clr
);

    localparam int unsigned CSR_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [CSR_W-1:0]          tohost_q, tohost_d;
    logic [CSR_W-1:0]          fromhost_q, fromhost_d;
    logic [HTIF_PCR_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                      req_hs, resp_hs;

    // Upper request bits beyond the 32-bit CSRs carry no meaning here.
    logic unused_req_data;
    assign unused_req_data = ^htif_pcr_req_data;

    assign htif_pcr_req_ready  = (state_q == IDLE);
    assign htif_pcr_resp_valid = (state_q == RESP);
    assign htif_pcr_resp_data  = resp_data_q;
    assign core_tohost         = tohost_q;
    assign core_fromhost       = fromhost_q;

    assign req_hs  = htif_pcr_req_valid  && (state_q == IDLE);
    assign resp_hs = htif_pcr_resp_ready && (state_q == RESP);

    // Next state, response capture and register side effects.
    always_comb begin
        state_d     = state_q;
        tohost_d    = tohost_q;
        fromhost_d  = fromhost_q;
        resp_data_d = resp_data_q;

        // Core clear is applied first so a same-edge host write overrides it.
        if (core_fromhost_clr) begin
            fromhost_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (req_hs) begin
                    state_d = RESP;
                    if (htif_pcr_req_addr == ADDR_TO_HOST) begin
                        resp_data_d = HTIF_PCR_WIDTH'(tohost_q);
                        tohost_d    = htif_pcr_req_rw ? htif_pcr_req_data[CSR_W-1:0] : '0;
                    end else if (htif_pcr_req_addr == ADDR_FROM_HOST) begin
                        resp_data_d = HTIF_PCR_WIDTH'(fromhost_q);
                        if (htif_pcr_req_rw) begin
                            fromhost_d = htif_pcr_req_data[CSR_W-1:0];
                        end
                    end else begin
                        resp_data_d = '0;
                    end
                end
            end
            RESP: begin
                if (resp_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Core write to tohost wins over any same-edge host access.
        if (core_tohost_wen) begin
            tohost_d = core_tohost_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            tohost_q    <= '0;
            fromhost_q  <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            tohost_q    <= tohost_d;
            fromhost_q  <= fromhost_d;
            resp_data_q <= resp_data_d;
        end
    end

endmodule

// File: tb/tb_vscale_htif_pcr_responder.sv
// Self-checking bench for vscale_htif_pcr_responder: directed scenarios plus
// randomized traffic against a transaction-level model of the CSR rules.
module tb_vscale_htif_pcr_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_rw = 1'b0;
    logic [11:0] req_addr = '0;
    logic [63:0] req_data = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_data;
    logic        th_wen = 1'b0;
    logic [31:0] th_wdata = '0;
    logic [31:0] tohost;
    logic [31:0] fromhost;
    logic        fh_clr = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: pending response flag, registers, held response.
    bit          m_busy = 1'b0;
    logic [31:0] m_to = '0;
    logic [31:0] m_from = '0;
    logic [63:0] m_resp = '0;

    vscale_htif_pcr_responder dut (
        .clk                 (clk),
        .reset               (reset),
        .htif_pcr_req_valid  (req_valid),
        .htif_pcr_req_ready  (req_ready),
        .htif_pcr_req_rw     (req_rw),
        .htif_pcr_req_addr   (req_addr),
        .htif_pcr_req_data   (req_data),
        .htif_pcr_resp_valid (resp_valid),
        .htif_pcr_resp_ready (resp_ready),
        .htif_pcr_resp_data  (resp_data),
        .core_tohost_wen     (th_wen),
        .core_tohost_wdata   (th_wdata),
        .core_tohost         (tohost),
        .core_fromhost       (fromhost),
        .core_fromhost_clr   (fh_clr)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_busy = 1'b0;
        m_to   = '0;
        m_from = '0;
        m_resp = '0;
    endtask

    // Apply one clock edge's worth of CSR rules to the model.
    task automatic model_edge();
        logic [31:0] to_n;
        logic [31:0] from_n;
        to_n   = m_to;
        from_n = m_from;
        if (fh_clr) from_n = 32'h0;
        if (!m_busy && req_valid) begin
            m_busy = 1'b1;
            if (req_addr == 12'h780) begin
                m_resp = {32'h0, m_to};
                to_n   = req_rw ? req_data[31:0] : 32'h0;
            end else if (req_addr == 12'h781) begin
                m_resp = {32'h0, m_from};
                if (req_rw) from_n = req_data[31:0];
            end else begin
                m_resp = 64'h0;
            end
        end else if (m_busy && resp_ready) begin
            m_busy = 1'b0;
        end
        if (th_wen) to_n = th_wdata;
        m_to   = to_n;
        m_from = from_n;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid  = 1'b0;
        req_rw     = 1'b0;
        resp_ready = 1'b0;
        th_wen     = 1'b0;
        fh_clr     = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        model_reset();
        #2;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        n_vec++; if (resp_data !== 64'h0) begin n_err++; $display("FAIL reset_resp_data got %h want 0", resp_data); end
        n_vec++; if (tohost !== 32'h0) begin n_err++; $display("FAIL reset_tohost got %h want 0", tohost); end
        n_vec++; if (fromhost !== 32'h0) begin n_err++; $display("FAIL reset_fromhost got %h want 0", fromhost); end
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_destructive_read();
        th_wen = 1'b1; th_wdata = 32'h1;
        tick();
        th_wen = 1'b0;
        n_vec++; if (tohost !== 32'h1) begin n_err++; $display("FAIL core_write_tohost got %h want 1", tohost); end
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 12'h780;
        tick();
        req_valid = 1'b0;
        n_vec++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL rd_resp_valid got %b want 1", resp_valid); end
        n_vec++; if (resp_data !== 64'h1) begin n_err++; $display("FAIL rd_resp_data got %h want 1", resp_data); end
        n_vec++; if (tohost !== 32'h0) begin n_err++; $display("FAIL rd_tohost_cleared got %h want 0", tohost); end
        n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rd_req_ready_in_resp got %b want 0", req_ready); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rd_resp_done got %b want 0", resp_valid); end
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 12'h780; resp_ready = 1'b1;
        n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_start got %b want 0", resp_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if (resp_valid !== ((i % 2) == 0)) begin
                n_err++; $display("FAIL b2b_valid[%0d] got %b want %b", i, resp_valid, (i % 2) == 0);
            end
            n_vec++;
            if (resp_data !== 64'h0) begin n_err++; $display("FAIL b2b_data[%0d] got %h want 0", i, resp_data); end
        end
        idle_inputs();
    endtask

    task automatic test_fromhost_write();
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 12'h781; req_data = 64'h5;
        tick();
        req_valid = 1'b0; resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_vec++; if (fromhost !== 32'h5) begin n_err++; $display("FAIL fh_setup got %h want 5", fromhost); end
        req_valid = 1'b1; req_data = 64'h1234_5678_DEAD_BEEF;
        tick();
        req_valid = 1'b0;
        n_vec++; if (resp_data !== 64'h5) begin n_err++; $display("FAIL fh_wr_prior got %h want 5", resp_data); end
        n_vec++; if (fromhost !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL fh_wr_new got %h want deadbeef", fromhost); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0; fh_clr = 1'b1;
        tick();
        n_vec++; if (fromhost !== 32'h0) begin n_err++; $display("FAIL fh_clr got %h want 0", fromhost); end
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 12'h781; req_data = 64'hDEAD_BEEF;
        tick();
        req_valid = 1'b0; fh_clr = 1'b0;
        n_vec++; if (fromhost !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL fh_host_wins got %h want deadbeef", fromhost); end
        n_vec++; if (resp_data !== 64'h0) begin n_err++; $display("FAIL fh_clr_race_resp got %h want 0", resp_data); end
        resp_ready = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_stall();
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 12'h781;
        tick();
        req_rw = 1'b1; req_addr = 12'h780; req_data = 64'h99;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d] got %b want 1", i, resp_valid); end
            n_vec++; if (resp_data !== 64'hDEAD_BEEF) begin n_err++; $display("FAIL stall_data[%0d] got %h want deadbeef", i, resp_data); end
            n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready[%0d] got %b want 0", i, req_ready); end
            n_vec++; if (tohost !== 32'h0) begin n_err++; $display("FAIL stall_no_accept[%0d] got %h want 0", i, tohost); end
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        tick();
        n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL stall_release got %b want 0", resp_valid); end
        idle_inputs();
    endtask

    task automatic test_core_race();
        th_wen = 1'b1; th_wdata = 32'h7;
        tick();
        th_wdata = 32'h2A; req_valid = 1'b1; req_rw = 1'b0; req_addr = 12'h780;
        tick();
        th_wen = 1'b0; req_valid = 1'b0;
        n_vec++; if (resp_data !== 64'h7) begin n_err++; $display("FAIL race_resp got %h want 7", resp_data); end
        n_vec++; if (tohost !== 32'h2A) begin n_err++; $display("FAIL race_core_wins got %h want 2a", tohost); end
        resp_ready = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_in_resp();
        fh_clr = 1'b0;
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 12'h780; req_data = 64'h55;
        tick();
        req_valid = 1'b0;
        n_vec++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL rir_pre_valid got %b want 1", resp_valid); end
        reset = 1'b0;
        model_reset();
        #2;
        n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rir_valid got %b want 0", resp_valid); end
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rir_ready got %b want 1", req_ready); end
        n_vec++; if (tohost !== 32'h0) begin n_err++; $display("FAIL rir_tohost got %h want 0", tohost); end
        n_vec++; if (fromhost !== 32'h0) begin n_err++; $display("FAIL rir_fromhost got %h want 0", fromhost); end
        reset = 1'b1;
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 12'h123;
        tick();
        req_valid = 1'b0;
        n_vec++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL rir_first_accept got %b want 1", resp_valid); end
        n_vec++; if (resp_data !== 64'h0) begin n_err++; $display("FAIL rir_other_addr got %h want 0", resp_data); end
        resp_ready = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            req_valid  = ($urandom_range(0, 2) != 0);
            req_rw     = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       req_addr = 12'h780;
                1:       req_addr = 12'h781;
                default: req_addr = 12'($urandom);
            endcase
            req_data   = {$urandom, $urandom};
            resp_ready = ($urandom_range(0, 2) != 0);
            th_wen     = ($urandom_range(0, 3) == 0);
            th_wdata   = $urandom;
            fh_clr     = ($urandom_range(0, 3) == 0);
            tick();
            n_vec++; if (resp_valid !== m_busy) begin n_err++; $display("FAIL rnd_valid[%0d] got %b want %b", i, resp_valid, m_busy); end
            n_vec++; if (req_ready !== !m_busy) begin n_err++; $display("FAIL rnd_ready[%0d] got %b want %b", i, req_ready, !m_busy); end
            n_vec++; if (resp_data !== m_resp) begin n_err++; $display("FAIL rnd_data[%0d] got %h want %h", i, resp_data, m_resp); end
            n_vec++; if (tohost !== m_to) begin n_err++; $display("FAIL rnd_tohost[%0d] got %h want %h", i, tohost, m_to); end
            n_vec++; if (fromhost !== m_from) begin n_err++; $display("FAIL rnd_fromhost[%0d] got %h want %h", i, fromhost, m_from); end
        end
        idle_inputs();
    endtask

    initial begin
        #12;
        test_reset();
        test_destructive_read();
        test_back_to_back();
        test_fromhost_write();
        test_stall();
        test_core_race();
        test_reset_in_resp();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vscale_htif_pcr_responder.md
VSCALE_HTIF_PCR_RESPONDER -- requirements
Module: vscale_htif_pcr_responder

Interface
REQ-001 SHALL have parameter HTIF_PCR_WIDTH, default 64: host data width.
REQ-002 SHALL have parameter ADDR_TO_HOST, default 12'h780: tohost CSR address.
REQ-003 SHALL have parameter ADDR_FROM_HOST, default 12'h781: fromhost CSR address.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port htif_pcr_req_valid  input  1  host request valid.
REQ-007 SHALL have port htif_pcr_req_ready  output  1  responder can accept a request.
REQ-008 SHALL have port htif_pcr_req_rw  input  1  1 = write, 0 = read.
REQ-009 SHALL have port htif_pcr_req_addr  input  12  CSR address.
REQ-010 SHALL have port htif_pcr_req_data  input  HTIF_PCR_WIDTH  write data.
REQ-011 SHALL have port htif_pcr_resp_valid  output  1  response valid.
REQ-012 SHALL have port htif_pcr_resp_ready  input  1  host accepts the response.
REQ-013 SHALL have port htif_pcr_resp_data  output  HTIF_PCR_WIDTH  response data.
REQ-014 SHALL have port core_tohost_wen  input  1  core writes tohost.
REQ-015 SHALL have port core_tohost_wdata  input  32  core tohost value.
REQ-016 SHALL have port core_tohost  output  32  current tohost register.
REQ-017 SHALL have port core_fromhost  output  32  current fromhost register.
REQ-018 SHALL have port core_fromhost_clr  input  1  core clears fromhost.

Function
REQ-019 SHALL implement FSM states IDLE and RESP. Request handshake = req_valid & req_ready, sampled on a rising clk edge; response handshake = resp_valid & resp_ready, same sampling.
REQ-020 SHALL assert req_ready only in IDLE and resp_valid only in RESP; both are combinational from state.
REQ-021 IDLE: on request handshake, SHALL latch resp_data, apply side effects, and go to RESP; otherwise SHALL stay in IDLE.
REQ-022 RESP: on response handshake, SHALL go to IDLE; otherwise SHALL hold resp_data and stay in RESP.
REQ-023 Latency: resp_valid SHALL rise on the cycle after request acceptance. With req_valid and resp_ready both tied 1, one transaction SHALL complete every 2 cycles.
REQ-024 Read of ADDR_TO_HOST SHALL return tohost zero-extended to HTIF_PCR_WIDTH and SHALL clear tohost to 0 on the accept edge (destructive read).
REQ-025 Read of ADDR_FROM_HOST SHALL return fromhost zero-extended; no side effect.
REQ-026 Write to ADDR_FROM_HOST SHALL load req_data[31:0] into fromhost and SHALL return the prior fromhost value.
REQ-027 Write to ADDR_TO_HOST SHALL load req_data[31:0] into tohost and SHALL return the prior tohost value.
REQ-028 Any other address SHALL return 0 with no side effect.
REQ-029 core_tohost_wen SHALL load core_tohost_wdata into tohost in any state.
REQ-030 core_fromhost_clr SHALL clear fromhost to 0 in any state.
REQ-031 Simultaneous core_tohost_wen and host tohost read/write on the same edge: the response SHALL carry the pre-edge tohost value, and tohost SHALL take core_tohost_wdata (core wins).
REQ-032 Simultaneous core_fromhost_clr and host fromhost write on the same edge: fromhost SHALL take the host data (host wins).
REQ-033 core_tohost and core_fromhost SHALL reflect register contents directly, with no delay.

Reset
REQ-034 Asserting reset low SHALL asynchronously force: state IDLE, tohost 0, fromhost 0, resp_data 0, resp_valid 0, req_ready 1.
REQ-035 Reset asserted in RESP SHALL abort the pending response with no further handshake. Any side effect already applied at accept SHALL be overwritten by reset values.
REQ-036 Reset deassertion SHALL take effect on the next rising clk edge; the first request may be accepted on that edge.

Verification
REQ-037 Core writes tohost=0x00000001; host reads 12'h780 -> resp_data 0x0000000000000001 one cycle later; tohost reads 0 after accept.
REQ-038 req_valid=1 and resp_ready=1 constantly, tohost=0 -> resp_valid toggles 0,1,0,1; each response = 0.
REQ-039 Host writes 12'h781 data 0xDEADBEEF with fromhost=0x5 -> resp_data 0x5; core_fromhost=0xDEADBEEF. The same edge with core_fromhost_clr=1 -> 0xDEADBEEF.
REQ-040 resp_ready held 0 for 5 cycles in RESP -> resp_valid and resp_data stable; req_ready 0; a second request is not accepted.
REQ-041 Host tohost read on the same edge as core_tohost_wen data 0x2A, old tohost 0x7 -> resp_data 0x7; tohost 0x2A.
REQ-042 Reset pulled low while in RESP -> resp_valid 0 immediately, without a clock edge; tohost 0; fromhost 0; req_ready 1.
